// File: rtl/uart_mmio_ctrl.sv
// uart_mmio_ctrl: MMIO bridge between the CPU data port and the on-chip UART.
// It buffers TX and RX bytes in small FIFOs, exposes a status register, and
// provides the free-running cycle and retired-instruction counters.
//
// Handshakes (valid/ready): a byte moves on a cycle where both valid and ready
// are high at the rising clk edge. Once valid is raised, the source holds it
// and its data stable until the transfer. On tx_*, this block is the source.
// On rx_*, this block is the sink; rx_ready depends only on registered state.
module uart_mmio_ctrl #(
  parameter int TX_DEPTH = 8,
  parameter int RX_DEPTH = 8
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] io_addr,
  input  logic [31:0] io_wdata,
  input  logic        io_we,
  input  logic        io_re,
  output logic [31:0] io_rdata,
  input  logic        inst_retire,
  output logic [7:0]  tx_data_out,
  output logic        tx_valid,
  input  logic        tx_ready,
  input  logic [7:0]  rx_data_in,
  input  logic        rx_valid,
  output logic        rx_ready
);

  localparam int TXAW = $clog2(TX_DEPTH);
  localparam int RXAW = $clog2(RX_DEPTH);
  localparam logic [TXAW:0] TX_ONE = 1;
  localparam logic [RXAW:0] RX_ONE = 1;

  localparam logic [7:0] A_STATUS  = 8'h00;
  localparam logic [7:0] A_RX_DATA = 8'h04;
  localparam logic [7:0] A_TX_DATA = 8'h08;
  localparam logic [7:0] A_CYCLE   = 8'h10;
  localparam logic [7:0] A_INSTR   = 8'h14;
  localparam logic [7:0] A_CNT_RST = 8'h18;

  // ---------------------------------------------------------------------------
  // Address decode (only the low byte of the address matters)
  // ---------------------------------------------------------------------------
  logic [7:0] w_addr;
  logic       w_wr_status;
  logic       w_wr_tx;
  logic       w_wr_cnt_rst;
  logic       w_rd_rx;
  logic       w_unused;

  assign w_addr       = io_addr[7:0];
  assign w_wr_status  = io_we && (w_addr == A_STATUS);
  assign w_wr_tx      = io_we && (w_addr == A_TX_DATA);
  assign w_wr_cnt_rst = io_we && (w_addr == A_CNT_RST);
  assign w_rd_rx      = io_re && (w_addr == A_RX_DATA);
  assign w_unused     = ^{io_addr[31:8], io_wdata[31:8]};

  // ---------------------------------------------------------------------------
  // TX FIFO: CPU writes push, transmitter handshake pops
  // ---------------------------------------------------------------------------
  logic [7:0]    r_tx_mem [TX_DEPTH];
  logic [TXAW:0] r_tx_wptr;
  logic [TXAW:0] r_tx_rptr;
  logic          w_tx_empty;
  logic          w_tx_full;
  logic          w_tx_pop;
  logic          w_tx_push;
  logic          w_tx_ovf;

  assign w_tx_empty = (r_tx_wptr == r_tx_rptr);
  assign w_tx_full  = (r_tx_wptr[TXAW] != r_tx_rptr[TXAW]) &&
                      (r_tx_wptr[TXAW-1:0] == r_tx_rptr[TXAW-1:0]);
  assign w_tx_pop   = !w_tx_empty && tx_ready;
  // A same-cycle pop frees a slot in a full FIFO, so the push still lands.
  assign w_tx_push  = w_wr_tx && (!w_tx_full || w_tx_pop);
  assign w_tx_ovf   = w_wr_tx && w_tx_full && !w_tx_pop;

  assign tx_valid    = !w_tx_empty;
  assign tx_data_out = r_tx_mem[r_tx_rptr[TXAW-1:0]];

  // TX storage write; contents need no reset because the pointers gate them.
  always_ff @(posedge clk) begin
    if (w_tx_push) begin
      r_tx_mem[r_tx_wptr[TXAW-1:0]] <= io_wdata[7:0];
    end
  end

  // TX pointer update; reset discards anything still buffered.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_tx_wptr <= '0;
      r_tx_rptr <= '0;
    end else begin
      if (w_tx_push) r_tx_wptr <= r_tx_wptr + TX_ONE;
      if (w_tx_pop)  r_tx_rptr <= r_tx_rptr + TX_ONE;
    end
  end

  // ---------------------------------------------------------------------------
  // RX FIFO: receiver handshake pushes, CPU reads of the data register pop
  // ---------------------------------------------------------------------------
  logic [7:0]    r_rx_mem [RX_DEPTH];
  logic [RXAW:0] r_rx_wptr;
  logic [RXAW:0] r_rx_rptr;
  logic          w_rx_empty;
  logic          w_rx_full;
  logic          w_rx_push;
  logic          w_rx_pop;
  logic          w_rx_ovf;
  logic [7:0]    w_rx_head;

  assign w_rx_empty = (r_rx_wptr == r_rx_rptr);
  assign w_rx_full  = (r_rx_wptr[RXAW] != r_rx_rptr[RXAW]) &&
                      (r_rx_wptr[RXAW-1:0] == r_rx_rptr[RXAW-1:0]);
  assign rx_ready   = !w_rx_full;
  assign w_rx_push  = rx_valid && !w_rx_full;
  // An empty FIFO is never popped, even if a byte arrives in the same cycle;
  // that byte stays for the next read.
  assign w_rx_pop   = w_rd_rx && !w_rx_empty;
  // A valid byte offered while full is counted as lost.
  assign w_rx_ovf   = rx_valid && w_rx_full;
  assign w_rx_head  = r_rx_mem[r_rx_rptr[RXAW-1:0]];

  // RX storage write.
  always_ff @(posedge clk) begin
    if (w_rx_push) begin
      r_rx_mem[r_rx_wptr[RXAW-1:0]] <= rx_data_in;
    end
  end

  // RX pointer update.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_rx_wptr <= '0;
      r_rx_rptr <= '0;
    end else begin
      if (w_rx_push) r_rx_wptr <= r_rx_wptr + RX_ONE;
      if (w_rx_pop)  r_rx_rptr <= r_rx_rptr + RX_ONE;
    end
  end

  // ---------------------------------------------------------------------------
  // Sticky overflow flags: any status write clears them, and a new event in
  // that same cycle takes priority so it is never missed.
  // ---------------------------------------------------------------------------
  logic r_tx_ovf;
  logic r_rx_ovf;

  // Set on overflow events and clear on status writes.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_tx_ovf <= 1'b0;
      r_rx_ovf <= 1'b0;
    end else begin
      if (w_wr_status) begin
        r_tx_ovf <= 1'b0;
        r_rx_ovf <= 1'b0;
      end
      if (w_tx_ovf) r_tx_ovf <= 1'b1;
      if (w_rx_ovf) r_rx_ovf <= 1'b1;
    end
  end

  // ---------------------------------------------------------------------------
  // Cycle and retired-instruction counters
  // ---------------------------------------------------------------------------
  logic [31:0] r_cycle_cnt;
  logic [31:0] r_instr_cnt;

  // Count cycles and retirements; a counter-reset write beats an increment.
  always_ff @(posedge clk) begin
    if (rst || w_wr_cnt_rst) begin
      r_cycle_cnt <= '0;
      r_instr_cnt <= '0;
    end else begin
      r_cycle_cnt <= r_cycle_cnt + 32'd1;
      if (inst_retire) r_instr_cnt <= r_instr_cnt + 32'd1;
    end
  end

  // ---------------------------------------------------------------------------
  // Read path: select from pre-edge state and register it, like a BRAM.
  // ---------------------------------------------------------------------------
  logic [31:0] w_rd_val;
  logic [31:0] r_rdata;

  // Select the read value for the decoded offset; unmapped reads give 0.
  always_comb begin
    w_rd_val = '0;
    case (w_addr)
      A_STATUS:  w_rd_val = {28'b0, r_tx_ovf, r_rx_ovf, !w_rx_empty, !w_tx_full};
      A_RX_DATA: w_rd_val = w_rx_empty ? 32'd0 : {24'b0, w_rx_head};
      A_CYCLE:   w_rd_val = r_cycle_cnt;
      A_INSTR:   w_rd_val = r_instr_cnt;
      default:   w_rd_val = '0;
    endcase
  end

  // Capture read data on the read strobe and hold it until the next read.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_rdata <= '0;
    end else if (io_re) begin
      r_rdata <= w_rd_val;
    end
  end

  assign io_rdata = r_rdata;

endmodule

// File: tb/tb_uart_mmio_ctrl.sv
// tb_uart_mmio_ctrl: directed, self-checking bench for uart_mmio_ctrl.
module tb_uart_mmio_ctrl;

  logic        clk;
  logic        rst;
  logic [31:0] io_addr;
  logic [31:0] io_wdata;
  logic        io_we;
  logic        io_re;
  logic [31:0] io_rdata;
  logic        inst_retire;
  logic [7:0]  tx_data_out;
  logic        tx_valid;
  logic        tx_ready;
  logic [7:0]  rx_data_in;
  logic        rx_valid;
  logic        rx_ready;

  int n_assert = 0;
  int n_fail   = 0;

  logic [31:0] exp_q[$];
  logic [7:0]  tx_q[$];
  logic [7:0]  rx_q[$];

  uart_mmio_ctrl #(.TX_DEPTH(8), .RX_DEPTH(8)) dut (
    .clk         (clk),
    .rst         (rst),
    .io_addr     (io_addr),
    .io_wdata    (io_wdata),
    .io_we       (io_we),
    .io_re       (io_re),
    .io_rdata    (io_rdata),
    .inst_retire (inst_retire),
    .tx_data_out (tx_data_out),
    .tx_valid    (tx_valid),
    .tx_ready    (tx_ready),
    .rx_data_in  (rx_data_in),
    .rx_valid    (rx_valid),
    .rx_ready    (rx_ready)
  );

  // Clock
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance one edge; inputs change and outputs are sampled 1 time unit later.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic wr(input logic [7:0] addr, input logic [31:0] data);
    io_we    = 1'b1;
    io_addr  = {24'h800000, addr};
    io_wdata = data;
    tick();
    io_we    = 1'b0;
  endtask

  // Push a TX byte the FIFO is expected to accept.
  task automatic wr_tx(input logic [7:0] b);
    tx_q.push_back(b);
    wr(8'h08, {24'hABCDEF, b});
  endtask

  // Read: expected value is queued when the strobe is driven, checked on output.
  task automatic rd(input string tag, input logic [7:0] addr, input logic [31:0] exp);
    exp_q.push_back(exp);
    io_re   = 1'b1;
    io_addr = {24'h800000, addr};
    tick();
    io_re   = 1'b0;
    chk(tag, io_rdata, exp_q.pop_front());
  endtask

  task automatic rd_rx(input string tag);
    logic [7:0] b;
    b = rx_q.pop_front();
    rd(tag, 8'h04, {24'b0, b});
  endtask

  // One transmitter handshake, checking the head byte against the scoreboard.
  task automatic tx_pulse(input string tag);
    logic [7:0] b;
    b = tx_q.pop_front();
    tx_ready = 1'b1;
    chk({tag, "_valid"}, {31'b0, tx_valid}, 32'd1);
    chk({tag, "_data"}, {24'b0, tx_data_out}, {24'b0, b});
    tick();
    tx_ready = 1'b0;
  endtask

  task automatic rx_send(input logic [7:0] b);
    rx_valid   = 1'b1;
    rx_data_in = b;
    chk("rx_ready_fill", {31'b0, rx_ready}, 32'd1);
    rx_q.push_back(b);
    tick();
    rx_valid = 1'b0;
  endtask

  initial begin
    rst = 1'b1; io_addr = '0; io_wdata = '0; io_we = 1'b0; io_re = 1'b0;
    inst_retire = 1'b0; tx_ready = 1'b0; rx_data_in = '0; rx_valid = 1'b0;
    repeat (3) tick();
    rst = 1'b0;

    // Reset state
    chk("rst_rdata", io_rdata, 32'd0);
    chk("rst_tx_valid", {31'b0, tx_valid}, 32'd0);
    chk("rst_rx_ready", {31'b0, rx_ready}, 32'd1);
    rd("status_reset", 8'h00, 32'h0000_0001);
    rd("unmapped_rd", 8'h0C, 32'h0);

    // TX basic ordering
    wr_tx(8'h41);
    wr_tx(8'h42);
    tx_pulse("tx_a");
    tx_pulse("tx_b");
    chk("tx_empty_after", {31'b0, tx_valid}, 32'd0);

    // Counters: clear, 10 cycles with 5 retirements
    wr(8'h18, 32'hFFFF_FFFF);
    for (int i = 0; i < 10; i++) begin
      inst_retire = (i % 2 == 0);
      tick();
    end
    inst_retire = 1'b0;
    rd("cycle_cnt", 8'h10, 32'd10);
    rd("instr_cnt", 8'h14, 32'd5);
    // Counter reset wins over a same-cycle retirement
    io_we = 1'b1; io_addr = 32'h8000_0018; inst_retire = 1'b1;
    tick();
    io_we = 1'b0; inst_retire = 1'b0;
    rd("instr_after_clr", 8'h14, 32'd0);
    rd("cycle_after_clr", 8'h10, 32'd1);

    // Fill TX with 8 bytes while the transmitter stalls
    for (int i = 0; i < 8; i++) wr_tx(8'h10 + 8'(i));
    // Fill RX with 8 bytes and no reads
    for (int i = 0; i < 8; i++) rx_send(8'h61 + 8'(i));
    chk("rx_ready_full", {31'b0, rx_ready}, 32'd0);
    rd("status_both_full", 8'h00, 32'h0000_0002);

    // TX overflow: 9th byte dropped
    wr(8'h08, 32'h0000_0099);
    rd("status_tx_ovf", 8'h00, 32'h0000_000A);
    // RX overflow: valid while full
    rx_valid = 1'b1; rx_data_in = 8'hEE;
    tick();
    rx_valid = 1'b0;
    rd("status_rx_ovf", 8'h00, 32'h0000_000E);
    wr(8'h00, 32'h0);
    rd("status_cleared", 8'h00, 32'h0000_0002);
    wr(8'h20, 32'h1234_5678);
    rd("unmapped_wr", 8'h00, 32'h0000_0002);

    // Drain RX in order, then read from empty
    for (int i = 0; i < 8; i++) rd_rx("rx_data");
    rd("rx_empty_read", 8'h04, 32'h0);
    rd("status_rx_empty", 8'h00, 32'h0000_0000);

    // RX push and pop in the same cycle while empty
    exp_q.push_back(32'h0);
    rx_valid = 1'b1; rx_data_in = 8'h77; io_re = 1'b1; io_addr = 32'h8000_0004;
    tick();
    rx_valid = 1'b0; io_re = 1'b0;
    chk("rx_pushpop_empty", io_rdata, exp_q.pop_front());
    rx_q.push_back(8'h77);
    rd_rx("rx_kept_byte");
    repeat (2) tick();
    chk("rdata_hold", io_rdata, 32'h0000_0077);

    // TX full: push in the same cycle as a pop is accepted
    tx_ready = 1'b1;
    io_we = 1'b1; io_addr = 32'h8000_0008; io_wdata = 32'h0000_00AA;
    chk("tx_pushpop_head", {24'b0, tx_data_out}, {24'b0, tx_q.pop_front()});
    tx_q.push_back(8'hAA);
    tick();
    io_we = 1'b0; tx_ready = 1'b0;
    rd("status_pushpop", 8'h00, 32'h0000_0000);
    for (int i = 0; i < 8; i++) tx_pulse("tx_drain");
    chk("tx_drained", {31'b0, tx_valid}, 32'd0);
    rd("status_final", 8'h00, 32'h0000_0001);

    // Reset mid-transfer discards buffered bytes
    wr(8'h08, 32'h55);
    rx_send(8'h33);
    rx_q.delete();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("rst_mid_tx_valid", {31'b0, tx_valid}, 32'd0);
    rd("rst_mid_rx_empty", 8'h04, 32'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
